// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: RV32I load/store funct3
// encodings, the responder state encoding and the word geometry.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } rsp_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word accesses: store byte enables and data
// replication, load lane selection with sign/zero extension, and the
// alignment / funct3 legality checks.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_steered,
   output logic [31:0] rdata_ext,
   output logic        misaligned,
   output logic        illegal_f3
);

   logic [31:0] shifted;

   // Selected lane moved down to bit 0; for aligned words this is the word itself.
   assign shifted = rdata_word >> {addr, 3'b000};

   // Legality: unsigned sizes exist only for loads, anything else is illegal.
   always_comb begin : legality
      misaligned = 1'b0;
      illegal_f3 = 1'b0;
      case (funct3)
         F3_B:    misaligned = 1'b0;
         F3_H:    misaligned = addr[0];
         F3_W:    misaligned = (addr != 2'b00);
         F3_BU:   illegal_f3 = we;
         F3_HU: begin
            illegal_f3 = we;
            misaligned = addr[0];
         end
         default: illegal_f3 = 1'b1;
      endcase
   end

   // Store steering: replicate the right-aligned data across lanes and let
   // the byte enables pick the target lanes. Errors and loads write nothing.
   always_comb begin : store_steer
      byte_en       = 4'b0000;
      wdata_steered = wdata;
      case (funct3)
         F3_B: begin
            byte_en       = 4'b0001 << addr;
            wdata_steered = {4{wdata[7:0]}};
         end
         F3_H: begin
            byte_en       = addr[1] ? 4'b1100 : 4'b0011;
            wdata_steered = {2{wdata[15:0]}};
         end
         F3_W:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
      if (!we || misaligned || illegal_f3)
         byte_en = 4'b0000;
   end

   // Load extension from the selected lane.
   always_comb begin : load_extend
      case (funct3)
         F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    rdata_ext = shifted;
         F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
         F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
         default: rdata_ext = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core's unified memory port: one request at
// a time, fixed access latency, sub-word loads/stores and error flagging.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 1..15");
   end

   rsp_state_t  state_q, state_nx;
   logic [3:0]  cnt_q;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr, r_wdata;

   logic        accept, enter_resp;
   logic        a_we;
   logic [2:0]  a_funct3;
   logic [31:0] a_addr, a_wdata;
   logic        oor, err;
   logic [AW-1:0] word_idx;
   logic [31:0] ram_word;

   logic [3:0]  byte_en;
   logic [31:0] wdata_steered, rdata_ext;
   logic        misaligned, illegal_f3;

   logic [31:0] ram [DEPTH_WORDS];

   assign accept     = req_valid && req_ready;
   assign enter_resp = (state_nx == ST_RESP);

   // With LATENCY=1 the response is formed on the accepting edge, so the
   // live request is used in IDLE; otherwise the captured copy is used.
   assign a_we     = (state_q == ST_IDLE) ? req_we     : r_we;
   assign a_funct3 = (state_q == ST_IDLE) ? req_funct3 : r_funct3;
   assign a_addr   = (state_q == ST_IDLE) ? req_addr   : r_addr;
   assign a_wdata  = (state_q == ST_IDLE) ? req_wdata  : r_wdata;

   assign oor      = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign err      = oor || misaligned || illegal_f3;
   assign word_idx = a_addr[AW+1:2];
   assign ram_word = oor ? 32'd0 : ram[word_idx];

   mem_lane_align u_align (
      .funct3        (a_funct3),
      .addr          (a_addr[1:0]),
      .we            (a_we),
      .wdata         (a_wdata),
      .rdata_word    (ram_word),
      .byte_en       (byte_en),
      .wdata_steered (wdata_steered),
      .rdata_ext     (rdata_ext),
      .misaligned    (misaligned),
      .illegal_f3    (illegal_f3)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin : state_reg
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_nx;
   end

   // Next-state: IDLE -> WAIT (or RESP for single-cycle latency) -> RESP -> IDLE.
   always_comb begin : next_state
      state_nx = state_q;
      case (state_q)
         ST_IDLE: if (req_valid) state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt_q == 4'd0) state_nx = ST_RESP;
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin : outputs
      req_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
   end

   // Request capture and latency countdown.
   always_ff @(posedge clk or posedge reset) begin : capture
      if (reset) begin
         cnt_q    <= 4'd0;
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
      end else if (accept) begin
         cnt_q    <= CNT_LOAD;
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Response data/error are loaded on the edge entering RESP and cleared otherwise.
   always_ff @(posedge clk or posedge reset) begin : rsp_reg
      if (reset) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_rdata <= (enter_resp && !err && !a_we) ? rdata_ext : 32'd0;
         rsp_err   <= enter_resp && err;
      end
   end

   // Store commit on the edge entering RESP; contents survive reset.
   always_ff @(posedge clk) begin : ram_write
      if (enter_resp && !oor) begin
         for (int b = 0; b < WORD_BYTES; b++)
            if (byte_en[b]) ram[word_idx][8*b +: 8] <= wdata_steered[8*b +: 8];
      end
   end

endmodule
